// File: rtl/quan_pkg.sv
// rtl/quan_pkg.sv - shared states, mode codes and sizing constants for the quantisation scale/bias loaders
package quan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WR,
    SERVE
  } state_t;

  localparam logic [3:0] QMODE_8B  = 4'd0;
  localparam logic [3:0] QMODE_16B = 4'd1;

  localparam int REGS_MODE0    = 64;
  localparam int REGS_MODE1    = 32;
  localparam int ROW_NUM_IN_SA = 16;

  // Number of scale words a tile needs, minus one (1 word in mode 0, ceil(ch/32) in mode 1)
  function automatic logic [1:0] last_word_idx(input logic [3:0] mode, input logic [6:0] ch_num);
    logic [7:0] words;
    words = (mode == QMODE_8B) ? 8'd1 : (({1'b0, ch_num} + 8'd31) >> 5);
    return 2'(words - 8'd1);
  endfunction

endpackage

// File: rtl/quan_row_stepper.sv
// rtl/quan_row_stepper.sv - output row counter: 0 = idle, 1..ROWS while active, done pulse after last row
module quan_row_stepper #(
  parameter int ROWS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step,
  output logic [5:0] row_idx,
  output logic       active,
  output logic       done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= 6'd0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        row_idx <= 6'd1;
        active  <= 1'b1;
      end else if (step && active) begin
        if (row_idx == 6'(ROWS)) begin
          row_idx <= 6'd0;
          active  <= 1'b0;
          done    <= 1'b1;
        end else begin
          row_idx <= row_idx + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/quan_scale_load_ctrl.sv
// rtl/quan_scale_load_ctrl.sv - per-tile E-scale loader: fetch 1-2 scale words, write scale regs, step rows
// Optional QUAN_SCALE_LOAD_PERF_EN adds the stall_cnt performance counter.
module quan_scale_load_ctrl #(
  parameter int ADDR_W        = 16,
  parameter int SCALE_WORD_W  = 512,
  parameter int ROW_NUM_IN_SA = 16,
  parameter int REGS_MODE0    = 64,
  parameter int REGS_MODE1    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_mode,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [6:0]              cmd_ch_num,
  output logic                    rd_req_valid,
  input  logic                    rd_req_ready,
  output logic [ADDR_W-1:0]       rd_req_addr,
  input  logic                    rd_rsp_valid,
  input  logic [SCALE_WORD_W-1:0] rd_rsp_data,
  output logic                    scale_set,
  output logic [3:0]              mode,
  output logic [SCALE_WORD_W-1:0] scale_word,
  output logic [7:0]              scale_reg_start,
  output logic [7:0]              scale_reg_size,
  output logic                    tile_ready,
  input  logic                    row_step,
  output logic [5:0]              next_out_sa_row_idx,
  output logic                    tile_done,
  output logic                    cmd_err
`ifdef QUAN_SCALE_LOAD_PERF_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  import quan_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [6:0]        ch_num_q;
  logic [1:0]        word_idx;
  logic [1:0]        word_last;
  logic [7:0]        remaining;
  logic              cmd_illegal;
  logic              row_start;

  assign cmd_illegal = (cmd_mode > QMODE_16B) || (cmd_ch_num == 7'd0) ||
                       ({1'b0, cmd_ch_num} > 8'(REGS_MODE0));
  assign remaining   = {1'b0, ch_num_q} - {1'b0, word_idx, 5'd0};
  assign row_start   = (state == WR) && (word_idx == word_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      cmd_err         <= 1'b0;
      rd_req_valid    <= 1'b0;
      rd_req_addr     <= '0;
      scale_set       <= 1'b0;
      mode            <= 4'd0;
      scale_word      <= '0;
      scale_reg_start <= 8'd0;
      scale_reg_size  <= 8'd0;
      base_addr       <= '0;
      ch_num_q        <= 7'd0;
      word_idx        <= 2'd0;
      word_last       <= 2'd0;
    end else begin
      cmd_err   <= 1'b0;
      scale_set <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_illegal) begin
              cmd_err <= 1'b1;
            end else begin
              mode         <= cmd_mode;
              base_addr    <= cmd_addr;
              ch_num_q     <= cmd_ch_num;
              word_idx     <= 2'd0;
              word_last    <= last_word_idx(cmd_mode, cmd_ch_num);
              rd_req_valid <= 1'b1;
              rd_req_addr  <= cmd_addr;
              cmd_ready    <= 1'b0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (rd_rsp_valid) begin
            scale_word <= rd_rsp_data;
            scale_set  <= 1'b1;
            if (mode == QMODE_8B) begin
              scale_reg_start <= 8'd1;
              scale_reg_size  <= {1'b0, ch_num_q};
            end else begin
              scale_reg_start <= 8'd1 + {1'b0, word_idx, 5'd0};
              scale_reg_size  <= (remaining > 8'(REGS_MODE1)) ? 8'(REGS_MODE1) : remaining;
            end
            state <= WR;
          end
        end
        WR: begin
          if (word_idx != word_last) begin
            word_idx     <= word_idx + 2'd1;
            rd_req_valid <= 1'b1;
            rd_req_addr  <= base_addr + ADDR_W'(word_idx + 2'd1);
            state        <= REQ;
          end else begin
            state <= SERVE;
          end
        end
        SERVE: begin
          if (row_step && next_out_sa_row_idx == 6'(ROW_NUM_IN_SA)) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  quan_row_stepper #(
    .ROWS(ROW_NUM_IN_SA)
  ) u_row_stepper (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (row_start),
    .step    (row_step && (state == SERVE)),
    .row_idx (next_out_sa_row_idx),
    .active  (tile_ready),
    .done    (tile_done)
  );

`ifdef QUAN_SCALE_LOAD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (((state == REQ && !rd_req_ready) || state == WAIT) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quan_scale_load_ctrl.sv
// tb/tb_quan_scale_load_ctrl.sv - directed table-driven bench for quan_scale_load_ctrl
module tb_quan_scale_load_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_mode;
  logic [15:0]  cmd_addr;
  logic [6:0]   cmd_ch_num;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [15:0]  rd_req_addr;
  logic         rd_rsp_valid;
  logic [511:0] rd_rsp_data;
  logic         scale_set;
  logic [3:0]   mode;
  logic [511:0] scale_word;
  logic [7:0]   scale_reg_start;
  logic [7:0]   scale_reg_size;
  logic         tile_ready;
  logic         row_step;
  logic [5:0]   next_out_sa_row_idx;
  logic         tile_done;
  logic         cmd_err;
`ifdef QUAN_SCALE_LOAD_PERF_EN
  logic [31:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  quan_scale_load_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_mode            (cmd_mode),
    .cmd_addr            (cmd_addr),
    .cmd_ch_num          (cmd_ch_num),
    .rd_req_valid        (rd_req_valid),
    .rd_req_ready        (rd_req_ready),
    .rd_req_addr         (rd_req_addr),
    .rd_rsp_valid        (rd_rsp_valid),
    .rd_rsp_data         (rd_rsp_data),
    .scale_set           (scale_set),
    .mode                (mode),
    .scale_word          (scale_word),
    .scale_reg_start     (scale_reg_start),
    .scale_reg_size      (scale_reg_size),
    .tile_ready          (tile_ready),
    .row_step            (row_step),
    .next_out_sa_row_idx (next_out_sa_row_idx),
    .tile_done           (tile_done),
    .cmd_err             (cmd_err)
`ifdef QUAN_SCALE_LOAD_PERF_EN
    ,
    .stall_cnt           (stall_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  mode;
    logic [15:0] addr;
    logic [6:0]  ch;
    int          rdy_dly;
    int          rsp_dly;
    logic        err;
    int          nwords;
    logic [7:0]  s0;
    logic [7:0]  z0;
    logic [7:0]  s1;
    logic [7:0]  z1;
  } vec_t;

  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [511:0] data;
    logic [15:0]  exp_addr;
    int           exp_stall;
`ifdef QUAN_SCALE_LOAD_PERF_EN
    logic [31:0]  stall0;
    stall0 = stall_cnt;
`endif
    exp_stall = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_mode   = v.mode;
    cmd_addr   = v.addr;
    cmd_ch_num = v.ch;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.err) begin
      chk("cmd_err_pulse", cmd_err, 1);
      chk("err_cmd_ready", cmd_ready, 1);
      chk("err_no_req", rd_req_valid, 0);
      @(negedge clk);
      chk("cmd_err_clear", cmd_err, 0);
      chk("err_no_req2", rd_req_valid, 0);
      chk("err_cmd_ready2", cmd_ready, 1);
      return;
    end
    chk("cmd_ready_busy", cmd_ready, 0);
    for (int w = 0; w < v.nwords; w++) begin
      exp_addr = v.addr + 16'(w);
      chk("req_valid", rd_req_valid, 1);
      chk("req_addr", rd_req_addr, exp_addr);
      for (int k = 0; k < v.rdy_dly; k++) begin
        @(negedge clk);
        chk("req_valid_hold", rd_req_valid, 1);
        chk("req_addr_hold", rd_req_addr, exp_addr);
      end
      rd_req_ready = 1'b1;
      @(negedge clk);
      rd_req_ready = 1'b0;
      chk("req_valid_drop", rd_req_valid, 0);
      for (int k = 0; k < v.rsp_dly; k++) begin
        @(negedge clk);
        chk("no_set_in_wait", scale_set, 0);
      end
      exp_stall += v.rdy_dly + v.rsp_dly + 1;
      data         = {16{8'(id), 8'(w), 16'hC0DE}};
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = data;
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      chk("scale_set", scale_set, 1);
      chk("reg_start", scale_reg_start, (w == 0) ? v.s0 : v.s1);
      chk("reg_size", scale_reg_size, (w == 0) ? v.z0 : v.z1);
      chk("scale_word", scale_word == data, 1);
      chk("mode", mode, v.mode);
      @(negedge clk);
      chk("scale_set_clear", scale_set, 0);
      chk("word_held", scale_word == data, 1);
    end
    chk("tile_ready", tile_ready, 1);
    for (int r = 1; r <= 16; r++) begin
      chk("row_idx", next_out_sa_row_idx, r);
      chk("tile_done_low", tile_done, 0);
      row_step = 1'b1;
      @(negedge clk);
      row_step = 1'b0;
    end
    chk("tile_done", tile_done, 1);
    chk("row_idx_end", next_out_sa_row_idx, 0);
    chk("tile_ready_end", tile_ready, 0);
    chk("cmd_ready_end", cmd_ready, 1);
    @(negedge clk);
    chk("tile_done_pulse", tile_done, 0);
`ifdef QUAN_SCALE_LOAD_PERF_EN
    chk("stall_delta", stall_cnt - stall0, exp_stall);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd0, 16'h0010, 7'd64, 0, 1, 1'b0, 1, 8'd1, 8'd64, 8'd0, 8'd0};
    vecs[1] = '{4'd1, 16'h0020, 7'd64, 1, 0, 1'b0, 2, 8'd1, 8'd32, 8'd33, 8'd32};
    vecs[2] = '{4'd1, 16'h0030, 7'd40, 0, 2, 1'b0, 2, 8'd1, 8'd32, 8'd33, 8'd8};
    vecs[3] = '{4'd0, 16'h0040, 7'd17, 5, 0, 1'b0, 1, 8'd1, 8'd17, 8'd0, 8'd0};
    vecs[4] = '{4'd1, 16'hFFFF, 7'd20, 0, 0, 1'b0, 1, 8'd1, 8'd20, 8'd0, 8'd0};
    vecs[5] = '{4'd2, 16'h0050, 7'd8,  0, 0, 1'b1, 0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[6] = '{4'd0, 16'h0060, 7'd0,  0, 0, 1'b1, 0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[7] = '{4'd1, 16'h0070, 7'd65, 0, 0, 1'b1, 0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[8] = '{4'd15, 16'h0080, 7'd1, 0, 0, 1'b1, 0, 8'd0, 8'd0, 8'd0, 8'd0};

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_mode     = 4'd0;
    cmd_addr     = 16'd0;
    cmd_ch_num   = 7'd0;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    row_step     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", rd_req_valid, 0);
    chk("rst_scale_set", scale_set, 0);
    chk("rst_tile_ready", tile_ready, 0);
    chk("rst_row_idx", next_out_sa_row_idx, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst_n = 1'b1;
    row_step = 1'b1;
    @(negedge clk);
    row_step = 1'b0;
    chk("idle_row_step_ignored", next_out_sa_row_idx, 0);
    chk("idle_tile_done", tile_done, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while waiting for the response; a late response must not produce a write
    cmd_valid  = 1'b1;
    cmd_mode   = 4'd0;
    cmd_addr   = 16'h0005;
    cmd_ch_num = 7'd8;
    @(negedge clk);
    cmd_valid    = 1'b0;
    rd_req_ready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0;
    chk("wait_entered", rd_req_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_req_addr", rd_req_addr, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_size", scale_reg_size, 0);
    chk("midrst_tile_ready", tile_ready, 0);
`ifdef QUAN_SCALE_LOAD_PERF_EN
    chk("midrst_stall", stall_cnt, 0);
`endif
    rst_n        = 1'b1;
    rd_rsp_valid = 1'b1;
    rd_rsp_data  = {16{32'hDEADBEEF}};
    @(negedge clk);
    rd_rsp_valid = 1'b0;
    chk("late_rsp_no_set", scale_set, 0);
    chk("late_rsp_word", scale_word == '0, 1);
    chk("late_rsp_idle", cmd_ready, 1);
    run_vec(vecs[2], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
